// File: rtl/axi_ad7124_up_axi.sv
// AXI4-Lite slave bridging to the single-cycle up_* register bus of the AD7124 banks.
// One transaction in flight; a missing bank acknowledge completes with SLVERR after TIMEOUT cycles.
module axi_ad7124_up_axi #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  up_clk,
    input  logic                  up_rstn,

    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,

    output logic                  up_wreq,
    output logic [13:0]           up_waddr,
    output logic [31:0]           up_wdata,
    input  logic                  up_wack,
    output logic                  up_rreq,
    output logic [13:0]           up_raddr,
    input  logic [31:0]           up_rdata,
    input  logic                  up_rack,

    output logic [2:0]            fsm_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WREQ  = 3'd1,
        S_WWAIT = 3'd2,
        S_BRESP = 3'd3,
        S_RREQ  = 3'd4,
        S_RWAIT = 3'd5,
        S_RRESP = 3'd6
    } state_t;

    state_t        state, state_n;
    logic          aw_held, w_held, aw_held_n, w_held_n;
    logic [13:0]   awaddr_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic          awready_q, wready_q, arready_q;
    logic          aw_hs, w_hs, ar_hs, wr_start;
    logic          unused_bits;

    // Every channel transfers on a cycle where valid and ready are both high at the rising
    // edge; a source keeps valid and payload stable until that edge, ready may toggle freely.
    assign aw_hs     = s_axi_awvalid & awready_q;
    assign w_hs      = s_axi_wvalid & wready_q;
    assign ar_hs     = s_axi_arvalid & s_axi_arready;
    assign wr_start  = (state == S_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
    assign aw_held_n = ~wr_start & (aw_held | aw_hs);
    assign w_held_n  = ~wr_start & (w_held | w_hs);
    assign cnt_last  = (cnt == CW'(TIMEOUT - 1));
    assign fsm_state = state;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr, s_axi_araddr};

    always_ff @(posedge up_clk) begin
        if (!up_rstn) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (wr_start)   state_n = S_WREQ;
                else if (ar_hs) state_n = S_RREQ;
            end
            S_WREQ:  state_n = S_WWAIT;
            S_WWAIT: if (up_wack || cnt_last) state_n = S_BRESP;
            S_BRESP: if (s_axi_bready) state_n = S_IDLE;
            S_RREQ:  state_n = S_RWAIT;
            S_RWAIT: if (up_rack || cnt_last) state_n = S_RRESP;
            S_RRESP: if (s_axi_rready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Reads yield to a write that is pending or presenting both halves this cycle.
    always_comb begin
        s_axi_awready = awready_q;
        s_axi_wready  = wready_q;
        s_axi_arready = arready_q & ~(s_axi_awvalid & s_axi_wvalid);
        s_axi_bvalid  = (state == S_BRESP);
        s_axi_rvalid  = (state == S_RRESP);
        up_wreq       = (state == S_WREQ);
        up_rreq       = (state == S_RREQ);
    end

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            up_waddr    <= '0;
            up_wdata    <= '0;
            up_raddr    <= '0;
            s_axi_bresp <= 2'b00;
            s_axi_rresp <= 2'b00;
            s_axi_rdata <= '0;
        end else begin
            awready_q <= (state_n == S_IDLE) & ~aw_held_n;
            wready_q  <= (state_n == S_IDLE) & ~w_held_n;
            arready_q <= (state_n == S_IDLE) & ~aw_held_n & ~w_held_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            if (aw_hs) awaddr_q <= s_axi_awaddr[15:2];
            if (w_hs)  wdata_q  <= s_axi_wdata;
            // Halves arriving in the start cycle bypass the holding registers.
            if (wr_start) begin
                up_waddr <= aw_held ? awaddr_q : s_axi_awaddr[15:2];
                up_wdata <= w_held ? wdata_q : s_axi_wdata;
            end
            if (ar_hs) up_raddr <= s_axi_araddr[15:2];

            if (state == S_WREQ || state == S_RREQ)
                cnt <= '0;
            else if ((state == S_WWAIT || state == S_RWAIT) && !cnt_last)
                cnt <= cnt + CW'(1);

            if (state == S_WWAIT) begin
                if (up_wack)       s_axi_bresp <= 2'b00;
                else if (cnt_last) s_axi_bresp <= 2'b10;
            end
            if (state == S_RWAIT) begin
                if (up_rack) begin
                    s_axi_rdata <= up_rdata;
                    s_axi_rresp <= 2'b00;
                end else if (cnt_last) begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_ad7124_up_axi.sv
// Bench for axi_ad7124_up_axi: directed vector table, corner sequences and random transactions
// checked against a transaction-level timing/response model.
module tb_axi_ad7124_up_axi;

    localparam int TIMEOUT = 16;
    localparam int W = 34;

    logic        up_clk = 1'b0;
    logic        up_rstn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [15:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [15:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        up_wreq, up_wack, up_rreq, up_rack;
    logic [13:0] up_waddr, up_raddr;
    logic [31:0] up_wdata, up_rdata;
    logic [2:0]  fsm_state;

    always #5 up_clk = ~up_clk;

    axi_ad7124_up_axi #(.ADDR_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .fsm_state(fsm_state)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;      // write data, or what the bank returns on a read
        int          aw_gap;
        int          w_gap;
        int          ack_dly;   // ack in WAIT cycle ack_dly (0 = first WAIT cycle)
        int          rdy_dly;   // cycles of bready/rready low after valid
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;   // address/data handshake cycle to valid cycle
    } txn_t;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  exp_q[$];
    logic [31:0]   mem [logic [13:0]];
    txn_t          vec[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge up_clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = '0;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb  = 4'hF;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = '0;
        s_axi_bready  = 1'b0; s_axi_rready = 1'b0;
        up_wack = 1'b0; up_rack = 1'b0; up_rdata = '0;
    endtask

    function automatic txn_t mk(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                                input int aw_gap, input int w_gap, input int ack_dly,
                                input int rdy_dly, input logic [1:0] resp,
                                input logic [31:0] rdata, input int lat);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.aw_gap = aw_gap; t.w_gap = w_gap;
        t.ack_dly = ack_dly; t.rdy_dly = rdy_dly; t.exp_resp = resp; t.exp_rdata = rdata;
        t.exp_lat = lat;
        return t;
    endfunction

    // Transaction-level model: ack in time gives OKAY one cycle after the ack, else SLVERR at TIMEOUT.
    function automatic txn_t model_expect(input txn_t t);
        bit ok;
        ok = (t.ack_dly < TIMEOUT);
        t.exp_lat   = ok ? 3 + t.ack_dly : 2 + TIMEOUT;
        t.exp_resp  = ok ? 2'b00 : 2'b10;
        t.exp_rdata = (!t.wr && ok) ? t.data : 32'h0;
        return t;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {25'b0, s_axi_awready, s_axi_wready, s_axi_arready,
              s_axi_bvalid, s_axi_rvalid, up_wreq, up_rreq}, 32'h0);
        check({tag, "_resp"}, {28'b0, s_axi_bresp, s_axi_rresp}, 32'h0);
        check({tag, "_rdata"}, s_axi_rdata, 32'h0);
        check({tag, "_addr"}, {4'b0, up_waddr, up_raddr}, 32'h0);
        check({tag, "_wdata"}, up_wdata, 32'h0);
    endtask

    task automatic run_txn(input txn_t t);
        int          hs_cyc, req_cyc, v_cyc, req_n;
        bit          a_done, w_done, fin, ack, v, rdy;
        logic [1:0]  v_resp, cur_resp;
        logic [31:0] v_data, cur_data;
        logic [W-1:0] exp;
        hs_cyc = -1; req_cyc = -1; v_cyc = -1; req_n = 0;
        a_done = 1'b0; w_done = !t.wr; fin = 1'b0;
        v_resp = '0; v_data = '0;
        exp_q.push_back({t.exp_resp, t.exp_rdata});
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            ack = (req_cyc >= 0) && (cyc == req_cyc + 1 + t.ack_dly);
            s_axi_bready = 1'b0; s_axi_rready = 1'b0;
            if (t.wr) begin
                s_axi_awvalid = !a_done && (cyc >= t.aw_gap); s_axi_awaddr = t.addr;
                s_axi_wvalid  = !w_done && (cyc >= t.w_gap);  s_axi_wdata  = t.data;
                up_wack = ack;
            end else begin
                s_axi_arvalid = !a_done; s_axi_araddr = t.addr;
                up_rack = ack;
            end
            up_rdata = ack ? t.data : $urandom();
            #1;
            if (hs_cyc < 0) begin
                if (t.wr) begin
                    if (s_axi_awvalid && s_axi_awready) a_done = 1'b1;
                    if (s_axi_wvalid && s_axi_wready) w_done = 1'b1;
                end else if (s_axi_arvalid && s_axi_arready) begin
                    a_done = 1'b1;
                end
                if (a_done && w_done) hs_cyc = cyc;
            end
            if (up_wreq || up_rreq) begin
                req_n++;
                if (req_n == 1) begin
                    req_cyc = cyc;
                    check("req_kind", {30'b0, up_wreq, up_rreq}, t.wr ? 32'h2 : 32'h1);
                    check("req_cycle", 32'(cyc), 32'(hs_cyc + 1));
                    if (t.wr) begin
                        check("up_waddr", {18'b0, up_waddr}, {18'b0, t.addr[15:2]});
                        check("up_wdata", up_wdata, t.data);
                    end else begin
                        check("up_raddr", {18'b0, up_raddr}, {18'b0, t.addr[15:2]});
                    end
                end
            end
            v        = t.wr ? s_axi_bvalid : s_axi_rvalid;
            cur_resp = t.wr ? s_axi_bresp : s_axi_rresp;
            cur_data = s_axi_rdata;
            if (v) begin
                check("busy_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
                if (v_cyc < 0) begin
                    v_cyc = cyc;
                    check("latency", 32'(cyc - hs_cyc), 32'(t.exp_lat));
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'h1);
                    end else begin
                        exp = exp_q.pop_front();
                        check("resp", {30'b0, cur_resp}, {30'b0, exp[33:32]});
                        if (!t.wr) check("rdata", cur_data, exp[31:0]);
                    end
                    v_resp = cur_resp; v_data = cur_data;
                end else begin
                    check("resp_stable", {30'b0, cur_resp}, {30'b0, v_resp});
                    if (!t.wr) check("rdata_stable", cur_data, v_data);
                end
            end
            rdy = v && (v_cyc >= 0) && (cyc >= v_cyc + t.rdy_dly);
            s_axi_bready = t.wr && rdy;
            s_axi_rready = !t.wr && rdy;
            if (rdy) fin = 1'b1;
            step();
        end
        idle_inputs();
        #1;
        check("txn_done", {31'b0, fin}, 32'h1);
        check("req_count", 32'(req_n), 32'h1);
        check("ready_after", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
    endtask

    initial begin
        int wreq_n, rreq_n, wreq_cyc, rreq_cyc, b_cyc, ar_cyc;
        bit done;

        idle_inputs();
        up_rstn = 1'b0;
        repeat (3) step();
        check_all_zero("por");
        up_rstn = 1'b1;
        step();
        check("por_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

        vec[0] = mk(1, 16'h0008, 32'hA5A5_5A5A, 0, 0, 0,   0, 2'b00, 32'h0, 3);
        vec[1] = mk(1, 16'h0010, 32'h1234_5678, 4, 0, 0,   5, 2'b00, 32'h0, 3);
        vec[2] = mk(0, 16'h0000, 32'h2020_0722, 0, 0, 0,   0, 2'b00, 32'h2020_0722, 3);
        vec[3] = mk(1, 16'h0020, 32'h0F0F_F0F0, 0, 0, 100, 0, 2'b10, 32'h0, 18);
        vec[4] = mk(0, 16'h0024, 32'hDEAD_BEEF, 0, 0, 100, 2, 2'b10, 32'h0, 18);
        vec[5] = mk(0, 16'h0028, 32'hCAFE_F00D, 0, 0, 15,  1, 2'b00, 32'hCAFE_F00D, 18);
        vec[6] = mk(1, 16'h002E, 32'h0BB0_1CC1, 0, 2, 3,   1, 2'b00, 32'h0, 6);
        vec[7] = mk(1, 16'h0030, 32'h7777_8888, 0, 0, 16,  3, 2'b10, 32'h0, 18);
        for (int i = 0; i < 8; i++) run_txn(vec[i]);

        // Late write ack after a timeout: arrives in IDLE, must be dropped.
        run_txn(vec[3]);
        up_wack = 1'b1;
        step();
        up_wack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_bvalid", {30'b0, s_axi_bvalid, up_wreq}, 32'h0);
            step();
        end
        run_txn(vec[0]);

        // AW, W and AR together: write first, AR right after the B handshake.
        wreq_n = 0; rreq_n = 0; wreq_cyc = -1; rreq_cyc = -1; b_cyc = -1; ar_cyc = -1; done = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            s_axi_awvalid = (cyc == 0); s_axi_awaddr = 16'h0030;
            s_axi_wvalid  = (cyc == 0); s_axi_wdata  = 32'h5555_AAAA;
            s_axi_arvalid = (ar_cyc < 0); s_axi_araddr = 16'h0034;
            up_wack  = (wreq_cyc >= 0) && (cyc == wreq_cyc + 1);
            up_rack  = (rreq_cyc >= 0) && (cyc == rreq_cyc + 1);
            up_rdata = up_rack ? 32'h0BAD_F00D : 32'h0;
            s_axi_bready = 1'b1; s_axi_rready = 1'b1;
            #1;
            if (cyc == 0)
                check("sim_ready0", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h6);
            if (up_wreq) begin
                wreq_n++; wreq_cyc = cyc;
                check("sim_waddr", {18'b0, up_waddr}, 32'h00C);
            end
            if (up_rreq) begin
                rreq_n++; rreq_cyc = cyc;
                check("sim_rreq_after_b", {31'b0, b_cyc >= 0}, 32'h1);
                check("sim_raddr", {18'b0, up_raddr}, 32'h00D);
            end
            if (s_axi_arvalid && s_axi_arready) begin
                ar_cyc = cyc;
                check("sim_ar_cycle", 32'(cyc), 32'(b_cyc + 1));
            end
            if (s_axi_bvalid) begin
                b_cyc = cyc;
                check("sim_b_cycle", 32'(cyc), 32'h3);
                check("sim_bresp", {30'b0, s_axi_bresp}, 32'h0);
            end
            if (s_axi_rvalid) begin
                check("sim_r_cycle", 32'(cyc), 32'(ar_cyc + 3));
                check("sim_rdata", s_axi_rdata, 32'h0BAD_F00D);
                done = 1'b1;
            end
            step();
        end
        idle_inputs();
        check("sim_done", {31'b0, done}, 32'h1);
        check("sim_req_counts", {wreq_n[15:0], rreq_n[15:0]}, 32'h0001_0001);
        step();

        // Reset while waiting for a write ack.
        s_axi_awvalid = 1'b1; s_axi_awaddr = 16'h0040;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h1357_9BDF;
        step();
        idle_inputs();
        step();
        step();
        up_rstn = 1'b0;
        step();
        up_rstn = 1'b1;
        check_all_zero("rst_wwait");
        up_wack = 1'b1;
        step();
        up_wack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_no_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
            step();
        end
        run_txn(vec[2]);

        for (int i = 0; i < 40; i++) begin
            txn_t t;
            int   sel;
            t.wr     = 1'($urandom_range(0, 1));
            t.addr   = {10'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            t.aw_gap = t.wr ? int'($urandom_range(0, 3)) : 0;
            t.w_gap  = t.wr ? int'($urandom_range(0, 3)) : 0;
            sel      = int'($urandom_range(0, 9));
            t.ack_dly = (sel < 7) ? int'($urandom_range(0, 4)) :
                        (sel == 7) ? TIMEOUT - 1 : (sel == 8) ? TIMEOUT : TIMEOUT + 5;
            t.rdy_dly = int'($urandom_range(0, 3));
            if (t.wr) t.data = $urandom();
            else      t.data = mem.exists(t.addr[15:2]) ? mem[t.addr[15:2]] : $urandom();
            t = model_expect(t);
            run_txn(t);
            if (t.wr && t.ack_dly < TIMEOUT) mem[t.addr[15:2]] = t.data;
        end

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_ad7124_up_axi.md
# axi_ad7124_up_axi

AXI4-Lite slave to `up_*` register-bus bridge; the initiator that drives `up_wreq`/`up_rreq` into the AD7124 register banks and waits for their `up_wack`/`up_rack`. It converts each AXI4-Lite transaction into one single-cycle `up_*` request and returns the response on the B or R channel. If the bank never acknowledges, a timeout completes the transaction with SLVERR. It sits between the PS interconnect and all `axi_ad7124_*` register banks.

## Interface
- `ADDR_WIDTH`, 16: AXI byte-address width, minimum 16; word address = `addr[15:2]`, higher bits ignored.
- `TIMEOUT`, 255: maximum WAIT-state cycles before SLVERR; legal range 2..65535.

- `up_clk` in 1: single clock for AXI and `up_*`.
- `up_rstn` in 1: reset, synchronous, active-low.
- `s_axi_awvalid`/`s_axi_awready` in/out 1; `s_axi_awaddr` in ADDR_WIDTH; `s_axi_awprot` in 3 (ignored).
- `s_axi_wvalid`/`s_axi_wready` in/out 1; `s_axi_wdata` in 32; `s_axi_wstrb` in 4 (ignored, full-word writes).
- `s_axi_bvalid` out 1; `s_axi_bready` in 1; `s_axi_bresp` out 2.
- `s_axi_arvalid`/`s_axi_arready` in/out 1; `s_axi_araddr` in ADDR_WIDTH; `s_axi_arprot` in 3 (ignored).
- `s_axi_rvalid` out 1; `s_axi_rready` in 1; `s_axi_rdata` out 32; `s_axi_rresp` out 2.
- `up_wreq` out 1: write request, one-cycle pulse. `up_waddr` out 14. `up_wdata` out 32.
- `up_wack` in 1: write acknowledge.
- `up_rreq` out 1: read request, one-cycle pulse. `up_raddr` out 14.
- `up_rdata` in 32: read data, valid with `up_rack`.
- `up_rack` in 1: read acknowledge.

## Operation
- States: IDLE, WREQ, WWAIT, BRESP, RREQ, RWAIT, RRESP. Only one transaction is outstanding at a time.
- **IDLE, address and data capture:**
  - `awready` = IDLE and no AW held. `wready` = IDLE and no W held.
  - AW and W are captured independently, in either order or in the same cycle.
- **IDLE, write start:** when both AW and W are held, go to WREQ and clear both held flags.
- **IDLE, read acceptance:** `arready` = IDLE and no AW held and no W held and not (`awvalid` and `wvalid`). Writes therefore have priority. A held partial write (AW without W, or W without AW) blocks reads until it completes. AR handshake goes to RREQ.
- **WREQ:** `up_wreq`=1 for exactly this cycle. `up_waddr`/`up_wdata` come from the captured values and are held stable until the next write request. Next state is WWAIT, with the counter cleared.
- **WWAIT:**
  - `up_wack`=1: go to BRESP with `bresp`=2'b00.
  - No ack with counter = TIMEOUT-1: go to BRESP with `bresp`=2'b10.
  - Otherwise increment the counter.
- **BRESP:** `bvalid`=1 and `bresp` held until `bready`, then IDLE.
- **RREQ, RWAIT, RRESP:** same as the write path, using `up_rreq`/`up_rack`.
  - On ack, `rdata` is captured from `up_rdata` with `rresp`=2'b00.
  - On timeout, `rdata`=32'h0 with `rresp`=2'b10.
  - `rvalid`, `rdata` and `rresp` are held until `rready`.
- **Ack sampling:** `up_wack` is sampled only in WWAIT and `up_rack` only in RWAIT. Acks in any other state, including late acks after a timeout, are dropped.
- **Reset values:** all AXI ready/valid outputs 0, `bresp`/`rresp` 0, `rdata` 0, `up_wreq`/`up_rreq` 0, `up_waddr`/`up_raddr`/`up_wdata` 0, held flags cleared, state IDLE.
- **Reset mid-transaction:** the transaction is abandoned with no response issued. Any in-flight ack is ignored.

## Timing
- **Write:** AW+W handshake cycle 0, `up_wreq` cycle 1, earliest `up_wack` cycle 2, `bvalid` cycle 3.
- **Read:** AR handshake cycle 0, `up_rreq` cycle 1, `up_rack`+`up_rdata` cycle 2, `rvalid` with captured data cycle 3.
- **Valid after ack:** `bvalid`/`rvalid` assert the cycle after the ack; an ack in WAIT cycle k gives valid at k+1.
- **Timeout:** WAIT spans at most TIMEOUT cycles. With no ack, `*valid` asserts at handshake + 2 + TIMEOUT.
- **Readiness:** the earliest next AW/W/AR acceptance is the cycle after the `bready`/`rready` handshake, i.e. ready is asserted in IDLE.
- **Combinational path:** `arready` is combinational from `awvalid`/`wvalid`. All other outputs are registered.
- **Counter width:** `$clog2(TIMEOUT+1)`; it never wraps.

## Test plan
- **Write to 0x08, slave acks after one cycle:** AW addr 0x0008 and W data 0xA5A5_5A5A in cycle 0 → `up_wreq` pulse cycle 1 with `up_waddr`=0x002, `up_wdata`=0xA5A5_5A5A → `bvalid` cycle 3, `bresp`=00.
- **W before AW with backpressure:** W in cycle 0, AW in cycle 4, `bready` low for 5 cycles → single `up_wreq` in cycle 5; `bvalid` is held stable until `bready`; `awready`/`wready` stay 0 throughout.
- **Read of PCORE version:** AR 0x0000, slave returns 32'h2020_0722 with `rack` one cycle after `rreq` → `rvalid` cycle 3, `rdata`=32'h2020_0722, `rresp`=00.
- **Timeout, TIMEOUT=16, slave never acks:**
  - Write → `bvalid` cycle 18 with `bresp`=10.
  - Read → `rdata`=0, `rresp`=10.
  - A late `up_wack` in cycle 20 is ignored, and the next transaction completes normally.
- **Simultaneous AW+W+AR in cycle 0:** `arready`=0 and the write completes first. AR is accepted in the first IDLE cycle after the B handshake, and exactly one `up_rreq` follows.
- **Reset in WWAIT:** `up_rstn` low for 1 cycle → all outputs read 0 in the cycle after reset. A `up_wack` arriving after reset produces no `bvalid`, and the next read completes normally.
